// File: rtl/snitch_amo_initiator.sv
// snitch_amo_initiator: core load/store/AMO requests -> word-aligned SRAM AMO shim bank protocol.
// Optional macro SNITCH_AMO_INIT_SC_STATS_EN adds a saturating 16-bit SC-failure counter.
package snitch_amo_pkg;
    typedef enum logic [3:0] {
        AMONone = 4'h0,
        AMOSwap = 4'h1,
        AMOAdd  = 4'h2,
        AMOAnd  = 4'h3,
        AMOOr   = 4'h4,
        AMOXor  = 4'h5,
        AMOMax  = 4'h6,
        AMOMaxu = 4'h7,
        AMOMin  = 4'h8,
        AMOMinu = 4'h9,
        AMOLR   = 4'hA,
        AMOSC   = 4'hB
    } amo_op_e;
endpackage

module snitch_amo_initiator
    import snitch_amo_pkg::*;
#(
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned CoreIDWidth = 1,
    parameter int unsigned CoreId      = 0,
    parameter int unsigned RspDepth    = 2,
    parameter int unsigned StrbWidth   = DataWidth / 8,
    parameter int unsigned OffW        = $clog2(StrbWidth)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [AddrWidth-1:0]    req_addr_i,
    input  amo_op_e                 req_amo_i,
    input  logic                    req_write_i,
    input  logic [1:0]              req_size_i,
    input  logic [31:0]             req_data_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [31:0]             rsp_data_o,
    output logic                    rsp_err_o,
    output logic                    mem_valid_o,
    input  logic                    mem_ready_i,
    output logic [AddrWidth-OffW-1:0] mem_addr_o,
    output amo_op_e                 mem_amo_o,
    output logic                    mem_write_o,
    output logic [DataWidth-1:0]    mem_wdata_o,
    output logic [StrbWidth-1:0]    mem_wstrb_o,
    input  logic [DataWidth-1:0]    mem_rdata_i,
    output logic [CoreIDWidth-1:0]  mem_core_id_o,
    output logic                    mem_is_core_o,
    output logic                    mem_dma_access_o,
    output logic [15:0]             sc_fail_cnt_o
);

    localparam int unsigned PtrW = $clog2(RspDepth);
    localparam int unsigned CntW = $clog2(RspDepth + 1);

    logic [OffW-1:0]      off;
    logic                 misaligned, illegal, req_err;
    logic                 credit_ok, pop, push, hand;
    logic [CntW:0]        occupancy;
    logic                 p_valid, p_err, p_write;
    logic [OffW-1:0]      p_off;
    logic [1:0]           p_size;
    logic [31:0]          lane, push_data;
    logic [31:0]          fifo_data [RspDepth];
    logic                 fifo_err  [RspDepth];
    logic [PtrW-1:0]      wr_ptr, rd_ptr;
    logic [CntW-1:0]      count;
    logic [StrbWidth-1:0] strb_base;
    logic [OffW-1:0]      strb_shift;

    assign off = req_addr_i[OffW-1:0];

    always_comb begin
        misaligned = ((req_size_i == 2'd1) && req_addr_i[0])
                  || ((req_size_i == 2'd2) && (req_addr_i[1:0] != 2'b00));
        illegal    = (req_size_i == 2'd3)
                  || ((req_amo_i != AMONone) && (req_size_i != 2'd2))
                  || (req_write_i && (req_amo_i != AMONone));
    end
    assign req_err = misaligned | illegal;

    // The capture stage always lands in the FIFO next cycle, so it already holds a slot.
    assign pop       = rsp_valid_o & rsp_ready_i;
    assign push      = p_valid;
    assign occupancy = {1'b0, count} + (CntW+1)'(p_valid) - (CntW+1)'(pop);
    assign credit_ok = occupancy < (CntW+1)'(RspDepth);

    assign req_ready_o = ~rst_i & credit_ok & (req_err | mem_ready_i);
    assign mem_valid_o = ~rst_i & req_valid_i & credit_ok & ~req_err;
    assign hand        = req_valid_i & req_ready_o;

    assign mem_addr_o       = req_addr_i[AddrWidth-1:OffW];
    assign mem_amo_o        = req_amo_i;
    assign mem_write_o      = req_write_i;
    assign mem_core_id_o    = CoreIDWidth'(CoreId);
    assign mem_is_core_o    = 1'b1;
    assign mem_dma_access_o = 1'b0;

    always_comb begin
        case (req_size_i)
            2'd0:    mem_wdata_o = {StrbWidth{req_data_i[7:0]}};
            2'd1:    mem_wdata_o = {(StrbWidth/2){req_data_i[15:0]}};
            default: mem_wdata_o = {(StrbWidth/4){req_data_i}};
        endcase
    end

    // Loads and atomics always strobe the whole enclosing 32-bit word.
    always_comb begin
        strb_base  = StrbWidth'(4'hF);
        strb_shift = off;
        if (req_write_i) begin
            case (req_size_i)
                2'd0:    strb_base = StrbWidth'(1);
                2'd1:    strb_base = StrbWidth'(3);
                default: strb_base = StrbWidth'(4'hF);
            endcase
        end else begin
            strb_shift[1:0] = 2'b00;
        end
        mem_wstrb_o = strb_base << strb_shift;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) p_valid <= 1'b0;
        else       p_valid <= hand;
        if (hand) begin
            p_off   <= off;
            p_size  <= req_size_i;
            p_err   <= req_err;
            p_write <= req_write_i;
        end
    end

    assign lane = 32'(mem_rdata_i >> {p_off, 3'b000});

    always_comb begin
        case (p_size)
            2'd0:    push_data = {24'b0, lane[7:0]};
            2'd1:    push_data = {16'b0, lane[15:0]};
            default: push_data = lane;
        endcase
        if (p_err || p_write) push_data = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= push_data;
                fifo_err[wr_ptr]  <= p_err;
                wr_ptr <= (wr_ptr == PtrW'(RspDepth - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= (rd_ptr == PtrW'(RspDepth - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CntW'(push) - CntW'(pop);
        end
    end

    assign rsp_valid_o = (count != '0);
    assign rsp_data_o  = rsp_valid_o ? fifo_data[rd_ptr] : '0;
    assign rsp_err_o   = rsp_valid_o & fifo_err[rd_ptr];

`ifdef SNITCH_AMO_INIT_SC_STATS_EN
    logic        p_sc;
    logic [15:0] sc_fail_cnt;

    always_ff @(posedge clk_i) begin
        if (hand) p_sc <= (req_amo_i == AMOSC);
        if (rst_i) sc_fail_cnt <= '0;
        else if (push && p_sc && !p_err && push_data[0] && (sc_fail_cnt != '1))
            sc_fail_cnt <= sc_fail_cnt + 16'd1;
    end
    assign sc_fail_cnt_o = sc_fail_cnt;
`else
    assign sc_fail_cnt_o = '0;
`endif

endmodule

// File: doc/snitch_amo_initiator.md
Name: snitch_amo_initiator

Overview:
- Requester-side adapter that turns core load/store/AMO/LR/SC requests (byte address, 32-bit data) into the word-aligned bank protocol served by the SRAM AMO shim: word address, positioned write data and strobes, and AMO opcode.
- Captures the bank read data exactly one cycle after each accepted request and extracts the addressed lane.
- Returns responses through a credit-protected response FIFO, so the bank side never stalls on response backpressure.
- Sits between a core's TCDM request port and one bank's shim.

Parameters:
AddrWidth, 32, byte-address width of core requests.
DataWidth, 64, bank word width; 32 or 64 only.
CoreIDWidth, 1, width of the core-ID field.
CoreId, 0, constant core ID driven with every request.
RspDepth, 2, response FIFO entries (≥2).
StrbWidth, DataWidth/8, derived; do not override.
OffW, $clog2(StrbWidth), derived byte-offset width.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  1  core request valid
req_ready_o  out  1  core request accepted
req_addr_i  in  AddrWidth  byte address
req_amo_i  in  amo_op_e  AMO type; AMONone for plain load/store
req_write_i  in  1  store (must be 0 for AMO/LR/SC)
req_size_i  in  2  0=byte, 1=half, 2=word; 3 is illegal
req_data_i  in  32  store data / AMO operand
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed
rsp_data_o  out  32  load data, AMO old value, or SC result (0=success, 1=fail)
rsp_err_o  out  1  misaligned or illegal request
mem_valid_o  out  1  bank request
mem_ready_i  in  1  bank ready
mem_addr_o  out  AddrWidth-OffW  word address
mem_amo_o  out  amo_op_e  AMO type
mem_write_o  out  1  write
mem_wdata_o  out  DataWidth  write data
mem_wstrb_o  out  StrbWidth  byte strobes
mem_rdata_i  in  DataWidth  read data, valid one cycle after handshake
mem_core_id_o  out  CoreIDWidth  = CoreId
mem_is_core_o  out  1  constant 1
mem_dma_access_o  out  1  constant 0
sc_fail_cnt_o  out  16  SC failure count (see Optional Feature)

Behaviour:
- Reset values: rsp_valid_o=0, mem_valid_o=0, req_ready_o=0, rsp_err_o=0, rsp_data_o=0, sc_fail_cnt_o=0.
- While rst_i is high, any in-flight capture and all FIFO contents are discarded; nothing is issued.
- Credit: `credit_ok = fifo_count + p_valid - pop < RspDepth`, where `pop = rsp_valid_o & rsp_ready_i`.
  - `p_valid` is 1 in the cycle after a bank handshake or an error acceptance.
  - The combinational path rsp_ready_i→req_ready_o is intended.
- Legality:
  - Misaligned: half with addr[0]≠0, or word with addr[1:0]≠0.
  - Illegal: size 3; any AMO/LR/SC with size≠word; write with AMO≠AMONone.
- Legal request:
  - `mem_valid_o = req_valid_i & credit_ok`.
  - `req_ready_o = mem_ready_i & credit_ok`.
  - All mem_* fields are combinational from req_*.
- Illegal request:
  - Never reaches the bank; `req_ready_o = credit_ok`.
  - Produces a response with rsp_err_o=1 and rsp_data_o=0, one cycle later, in order.
- Address: mem_addr_o = req_addr_i[AddrWidth-1:OffW]; off = req_addr_i[OffW-1:0].
- Write data: req_data_i replicated across all lanes (byte ×StrbWidth, half ×StrbWidth/2, word ×StrbWidth/4).
- Strobes: mask (1, 3 or 0xF per size) << off. AMO/LR/SC and loads use the word mask, so wstrb = 4'hF << (4*off[OffW-1:2]).
- Capture register, loaded on handshake: p_valid, off, size, err. In the next cycle the FIFO is pushed with:
  - data = (mem_rdata_i >> 8*off) truncated to size, zero-extended to 32 bits;
  - err flag;
  - is_sc flag.
- Stores also produce a response (data 0), so every request yields exactly one response.
- Ordering: responses leave in request order.
  - FIFO push and pop may occur in the same cycle.
  - Full FIFO is never overrun because of credit; empty FIFO gives rsp_valid_o=0.
- AMO latency: the bank holds mem_ready_i low during the AMO read-modify-write. The initiator holds request fields stable while valid and not ready (valid never drops once asserted unless credit drops; the core keeps its request).
- Minimum latency: request handshake in cycle N → rsp_valid_o in cycle N+2 (capture register, then FIFO registered output).

Optional Feature:
- SNITCH_AMO_INIT_SC_STATS_EN defined: a 16-bit counter increments when a response with is_sc=1, err=0 and data[0]=1 is pushed into the FIFO.
  - Saturates at 0xFFFF; cleared by reset.
  - Drives sc_fail_cnt_o.
- Not defined: no counter is synthesised; sc_fail_cnt_o is tied to 0.

Test Plan:
- Byte store to 0x1005, data 0xAB, DataWidth=64 → mem_addr_o=0x200, wstrb=0x20, wdata=0xABAB…AB; response err=0, data=0 at N+2.
- Word load from 0x1004, bank returns 0x11223344_55667788 one cycle after handshake → rsp_data_o=0x11223344, wstrb=0xF0.
- AMOAdd word at 0x1000 with mem_ready_i low for 2 cycles → request fields held stable; response data equals the old value returned the cycle after the handshake.
- Back-to-back loads with rsp_ready_i=0, RspDepth=2 → exactly 2 handshakes, then req_ready_o=0; raising rsp_ready_i restores 1 request/cycle throughput, responses in order.
- Half load at 0x1001, or AMOSwap with size=byte → no mem_valid_o; response err=1 in order behind an earlier pending load.
- LR then SC with bank SC data 1, three times, with SNITCH_AMO_INIT_SC_STATS_EN → sc_fail_cnt_o=3; assert rst_i mid-flight → FIFO empty, counter 0, rsp_valid_o=0 next cycle.
